// File: rtl/std_cache_pkg.sv
// Shared dcache definitions: default geometry, derived index/way widths and flush FSM states.
package std_cache_pkg;

  localparam int unsigned DCACHE_NR_SETS = 256;
  localparam int unsigned DCACHE_NR_WAYS = 8;
  localparam int unsigned IDX_W          = $clog2(DCACHE_NR_SETS);
  localparam int unsigned WAY_W          = $clog2(DCACHE_NR_WAYS);

  typedef enum logic [3:0] {
    FLUSH_IDLE,
    FLUSH_INIT,
    FLUSH_INIT_INV,
    FLUSH_RD,
    FLUSH_RSP,
    FLUSH_WB,
    FLUSH_WBW,
    FLUSH_INV,
    FLUSH_ACK,
    FLUSH_HOLD
  } flush_state_e;

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit of in_i, empty_o when no bit is set.
module lzc #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  // Scan from the top down so the last hit, the lowest set bit, wins.
  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CNT_W'(i);
    end
  end

endmodule

// File: rtl/dcache_flush_unit.sv
// Flush responder for the write-back dcache: walks every set, writes back dirty lines, invalidates, acks.
// Optional power-up invalidate walk is enabled with `define DCACHE_FLUSH_INIT_EN.
module dcache_flush_unit
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_SETS  = DCACHE_NR_SETS,
  parameter int unsigned NR_WAYS  = DCACHE_NR_WAYS,
  parameter int unsigned TAG_W    = 44,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  output logic                                        flush_ack_o,
  output logic                                        busy_o,
  input  logic                                        cache_init_ni,
  output logic                                        meta_req_o,
  input  logic                                        meta_gnt_i,
  output logic                                        meta_we_o,
  output logic [$clog2(NR_SETS)-1:0]                  meta_idx_o,
  input  logic [NR_WAYS-1:0]                          meta_valid_i,
  input  logic [NR_WAYS-1:0]                          meta_dirty_i,
  input  logic [NR_WAYS*TAG_W-1:0]                    meta_tag_i,
  output logic                                        wb_valid_o,
  input  logic                                        wb_ready_i,
  output logic [TAG_W+$clog2(NR_SETS)+OFFSET_W-1:0]   wb_addr_o,
  output logic [$clog2(NR_WAYS)-1:0]                  wb_way_o,
  input  logic                                        wb_done_i
);

  localparam int unsigned IDX_BITS = $clog2(NR_SETS);
  localparam int unsigned WAY_BITS = $clog2(NR_WAYS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NR_SETS - 1);

`ifdef DCACHE_FLUSH_INIT_EN
  localparam flush_state_e RESET_STATE = FLUSH_INIT;
`else
  localparam flush_state_e RESET_STATE = FLUSH_IDLE;
  logic unused_cache_init;
  assign unused_cache_init = cache_init_ni;
`endif

  flush_state_e                state_q, state_d;
  logic [IDX_BITS-1:0]         idx_q, idx_d;
  logic [NR_WAYS-1:0]          pend_q, pend_d;
  logic [NR_WAYS*TAG_W-1:0]    tags_q, tags_d;
  logic [WAY_BITS-1:0]         wb_way;
  logic                        pend_empty;
  logic [NR_WAYS-1:0]          way_mask;
  logic [NR_WAYS-1:0]          pend_left;
  logic [TAG_W-1:0]            sel_tag;

  lzc #(
    .WIDTH (NR_WAYS)
  ) i_lzc (
    .in_i    (pend_q),
    .cnt_o   (wb_way),
    .empty_o (pend_empty)
  );

  assign way_mask  = NR_WAYS'(1) << wb_way;
  assign pend_left = pend_q & ~way_mask;
  assign sel_tag   = tags_q[int'(wb_way)*TAG_W +: TAG_W];

  // The writeback request is derived only from registered state, so it stays stable while stalled.
  assign meta_idx_o = idx_q;
  assign wb_addr_o  = (state_q == FLUSH_WB) ? {sel_tag, idx_q, {OFFSET_W{1'b0}}} : '0;
  assign wb_way_o   = (state_q == FLUSH_WB) ? wb_way : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      idx_q   <= '0;
      pend_q  <= '0;
      tags_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      tags_q  <= tags_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    tags_d      = tags_q;
    meta_req_o  = 1'b0;
    meta_we_o   = 1'b0;
    wb_valid_o  = 1'b0;
    flush_ack_o = 1'b0;
    busy_o      = (state_q != FLUSH_IDLE);

    unique case (state_q)
      FLUSH_IDLE: begin
        if (flush_i) state_d = FLUSH_RD;
      end
`ifdef DCACHE_FLUSH_INIT_EN
      FLUSH_INIT: begin
        state_d = cache_init_ni ? FLUSH_IDLE : FLUSH_INIT_INV;
      end
      FLUSH_INIT_INV: begin
        meta_req_o = 1'b1;
        meta_we_o  = 1'b1;
        if (meta_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = FLUSH_IDLE;
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
          end
        end
      end
`endif
      FLUSH_RD: begin
        meta_req_o = 1'b1;
        if (meta_gnt_i) state_d = FLUSH_RSP;
      end
      // Metadata arrives exactly one cycle after the granted read; capture all ways at once.
      FLUSH_RSP: begin
        pend_d  = meta_valid_i & meta_dirty_i;
        tags_d  = meta_tag_i;
        state_d = |(meta_valid_i & meta_dirty_i) ? FLUSH_WB : FLUSH_INV;
      end
      FLUSH_WB: begin
        wb_valid_o = 1'b1;
        if (pend_empty)      state_d = FLUSH_INV;
        else if (wb_ready_i) state_d = FLUSH_WBW;
      end
      FLUSH_WBW: begin
        if (wb_done_i) begin
          pend_d  = pend_left;
          state_d = |pend_left ? FLUSH_WB : FLUSH_INV;
        end
      end
      FLUSH_INV: begin
        meta_req_o = 1'b1;
        meta_we_o  = 1'b1;
        if (meta_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = FLUSH_ACK;
          end else begin
            idx_d   = idx_q + IDX_BITS'(1);
            state_d = FLUSH_RD;
          end
        end
      end
      FLUSH_ACK: begin
        flush_ack_o = 1'b1;
        state_d     = FLUSH_HOLD;
      end
      // One dead cycle lets the requester drop its registered request before we look again.
      FLUSH_HOLD: begin
        state_d = FLUSH_IDLE;
      end
      default: begin
        state_d = FLUSH_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Directed bench for dcache_flush_unit with a 4-set metadata array model and a writeback responder.
module tb_dcache_flush_unit;

  localparam int NS = 4;
  localparam int NW = 8;
  localparam int TW = 44;
  localparam int OW = 4;
  localparam int IW = 2;
  localparam int AW = TW + IW + OW;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           flush_i = 1'b0;
  logic           flush_ack_o;
  logic           busy_o;
  logic           cache_init_ni = 1'b1;
  logic           meta_req_o;
  logic           meta_gnt_i = 1'b1;
  logic           meta_we_o;
  logic [IW-1:0]  meta_idx_o;
  logic [NW-1:0]  meta_valid_i = '0;
  logic [NW-1:0]  meta_dirty_i = '0;
  logic [NW*TW-1:0] meta_tag_i = '0;
  logic           wb_valid_o;
  logic           wb_ready_i = 1'b0;
  logic [AW-1:0]  wb_addr_o;
  logic [2:0]     wb_way_o;
  logic           wb_done_i = 1'b0;

  dcache_flush_unit #(
    .NR_SETS (NS), .NR_WAYS (NW), .TAG_W (TW), .OFFSET_W (OW)
  ) dut (
    .clk_i (clk_i), .rst_i (rst_i), .flush_i (flush_i), .flush_ack_o (flush_ack_o),
    .busy_o (busy_o), .cache_init_ni (cache_init_ni), .meta_req_o (meta_req_o),
    .meta_gnt_i (meta_gnt_i), .meta_we_o (meta_we_o), .meta_idx_o (meta_idx_o),
    .meta_valid_i (meta_valid_i), .meta_dirty_i (meta_dirty_i), .meta_tag_i (meta_tag_i),
    .wb_valid_o (wb_valid_o), .wb_ready_i (wb_ready_i), .wb_addr_o (wb_addr_o),
    .wb_way_o (wb_way_o), .wb_done_i (wb_done_i)
  );

  always #5 clk_i = ~clk_i;

  logic [NW-1:0] valid_mem [NS];
  logic [NW-1:0] dirty_mem [NS];
  logic [TW-1:0] tag_mem   [NS][NW];

  int vec_cnt = 0, err_cnt = 0;
  int cyc = 0, rd_cnt = 0, inv_cnt = 0, wb_cnt = 0, ack_cnt = 0, stall_cyc = 0, stable_err = 0;
  int ready_delay = 0, done_delay = 0, stall_cnt = 0, done_timer = 0;
  bit pend_done = 0, have_prev = 0;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_way;
  logic [AW-1:0] acc_addr_q[$];
  logic [2:0]    acc_way_q[$];
  int            acc_cyc_q[$];
  int            done_cyc_q[$];

  // Metadata array model plus writeback monitor; everything is sampled on the rising edge.
  always @(posedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      if (meta_req_o && meta_gnt_i) begin
        if (meta_we_o) begin
          inv_cnt++;
          valid_mem[meta_idx_o] = '0;
          dirty_mem[meta_idx_o] = '0;
        end else begin
          rd_cnt++;
          meta_valid_i <= valid_mem[meta_idx_o];
          meta_dirty_i <= dirty_mem[meta_idx_o];
          for (int w = 0; w < NW; w++) meta_tag_i[w*TW +: TW] <= tag_mem[meta_idx_o][w];
        end
      end
      if (flush_ack_o) ack_cnt++;
      if (wb_valid_o) begin
        if (have_prev && (wb_addr_o !== prev_addr || wb_way_o !== prev_way)) stable_err++;
        if (wb_ready_i) begin
          wb_cnt++;
          acc_addr_q.push_back(wb_addr_o);
          acc_way_q.push_back(wb_way_o);
          acc_cyc_q.push_back(cyc);
          have_prev  = 0;
          pend_done  = 1;
          done_timer = done_delay;
        end else begin
          prev_addr = wb_addr_o;
          prev_way  = wb_way_o;
          have_prev = 1;
          stall_cyc++;
        end
      end else begin
        have_prev = 0;
      end
    end
  end

  // Writeback side: ready after ready_delay stalled cycles, done pulse done_delay cycles after accept.
  always @(negedge clk_i) begin
    if (wb_valid_o) begin
      wb_ready_i = (stall_cnt >= ready_delay);
      stall_cnt++;
    end else begin
      wb_ready_i = 1'b0;
      stall_cnt  = 0;
    end
    wb_done_i = 1'b0;
    if (pend_done) begin
      if (done_timer == 0) begin
        wb_done_i = 1'b1;
        pend_done = 0;
        done_cyc_q.push_back(cyc);
      end else begin
        done_timer--;
      end
    end
  end

  task automatic clear_mem();
    for (int s = 0; s < NS; s++) begin
      valid_mem[s] = '0;
      dirty_mem[s] = '0;
      for (int w = 0; w < NW; w++) tag_mem[s][w] = TW'(s * 16 + w + 1);
    end
  endtask

  task automatic clear_counters();
    rd_cnt = 0; inv_cnt = 0; wb_cnt = 0; ack_cnt = 0; stall_cyc = 0; stable_err = 0;
    acc_addr_q.delete(); acc_way_q.delete(); acc_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic do_flush(input int hold_after, input int drop_after,
                          output int ack_at, output int busy_gap);
    int n;
    clear_counters();
    ack_at = -1; busy_gap = 0; n = 0;
    flush_i = 1'b1;
    while (n < 400 && ack_at < 0) begin
      @(negedge clk_i);
      n++;
      if (drop_after > 0 && n == drop_after) flush_i = 1'b0;
      if (flush_ack_o) ack_at = n;
      else if (!busy_o) busy_gap++;
    end
    for (int i = 0; i < hold_after; i++) @(negedge clk_i);
    flush_i = 1'b0;
    for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    vec_cnt++; if (flush_ack_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_ack: got %b want 0", flush_ack_o); end
    vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    vec_cnt++; if (meta_req_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_meta_req: got %b want 0", meta_req_o); end
    vec_cnt++; if (wb_valid_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_wb_valid: got %b want 0", wb_valid_o); end
    vec_cnt++; if (meta_idx_o !== 2'd0) begin err_cnt++; $display("[TB] FAIL reset_idx: got %0d want 0", meta_idx_o); end
    vec_cnt++; if (wb_addr_o !== '0) begin err_cnt++; $display("[TB] FAIL reset_wb_addr: got %0h want 0", wb_addr_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_all_clean();
    int ack_at, gap;
    clear_mem();
    do_flush(0, 0, ack_at, gap);
    vec_cnt++; if (ack_at !== 13) begin err_cnt++; $display("[TB] FAIL clean_ack_cycle: got %0d want 13", ack_at); end
    vec_cnt++; if (rd_cnt !== 4) begin err_cnt++; $display("[TB] FAIL clean_reads: got %0d want 4", rd_cnt); end
    vec_cnt++; if (inv_cnt !== 4) begin err_cnt++; $display("[TB] FAIL clean_invalidates: got %0d want 4", inv_cnt); end
    vec_cnt++; if (wb_cnt !== 0) begin err_cnt++; $display("[TB] FAIL clean_wb: got %0d want 0", wb_cnt); end
    vec_cnt++; if (gap !== 0) begin err_cnt++; $display("[TB] FAIL clean_busy_gap: got %0d want 0", gap); end
    vec_cnt++; if (ack_cnt !== 1) begin err_cnt++; $display("[TB] FAIL clean_ack_width: got %0d want 1", ack_cnt); end
    vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL clean_idle_after: got %b want 0", busy_o); end
  endtask

  task automatic test_writeback();
    int ack_at, gap;
    logic [AW-1:0] exp_addr;
    clear_mem();
    valid_mem[2] = 8'b0110_0010;
    dirty_mem[2] = 8'b0010_0011;
    tag_mem[2][1] = 44'h3A;
    tag_mem[2][5] = 44'h3A;
    exp_addr = {44'h3A, 2'd2, 4'd0};
    ready_delay = 0; done_delay = 3;
    do_flush(0, 0, ack_at, gap);
    vec_cnt++; if (wb_cnt !== 2) begin err_cnt++; $display("[TB] FAIL wb_count: got %0d want 2", wb_cnt); end
    if (wb_cnt == 2) begin
      vec_cnt++; if (acc_way_q[0] !== 3'd1) begin err_cnt++; $display("[TB] FAIL wb_way0: got %0d want 1", acc_way_q[0]); end
      vec_cnt++; if (acc_way_q[1] !== 3'd5) begin err_cnt++; $display("[TB] FAIL wb_way1: got %0d want 5", acc_way_q[1]); end
      vec_cnt++; if (acc_addr_q[0] !== exp_addr) begin err_cnt++; $display("[TB] FAIL wb_addr0: got %0h want %0h", acc_addr_q[0], exp_addr); end
      vec_cnt++; if (acc_addr_q[1] !== exp_addr) begin err_cnt++; $display("[TB] FAIL wb_addr1: got %0h want %0h", acc_addr_q[1], exp_addr); end
      vec_cnt++;
      if (done_cyc_q.size() < 1 || acc_cyc_q[1] <= done_cyc_q[0]) begin
        err_cnt++; $display("[TB] FAIL wb_order: second accept cycle %0d not after first done", acc_cyc_q[1]);
      end
    end
    vec_cnt++; if (ack_cnt !== 1) begin err_cnt++; $display("[TB] FAIL wb_ack: got %0d want 1", ack_cnt); end
    vec_cnt++; if (inv_cnt !== 4) begin err_cnt++; $display("[TB] FAIL wb_invalidates: got %0d want 4", inv_cnt); end
  endtask

  task automatic test_ready_stall();
    int ack_at, gap;
    clear_mem();
    valid_mem[1] = 8'h80; dirty_mem[1] = 8'h80; tag_mem[1][7] = 44'h123;
    ready_delay = 5; done_delay = 1;
    do_flush(0, 0, ack_at, gap);
    vec_cnt++; if (stall_cyc !== 5) begin err_cnt++; $display("[TB] FAIL stall_cycles: got %0d want 5", stall_cyc); end
    vec_cnt++; if (stable_err !== 0) begin err_cnt++; $display("[TB] FAIL stall_stable: got %0d changes want 0", stable_err); end
    vec_cnt++; if (wb_cnt !== 1) begin err_cnt++; $display("[TB] FAIL stall_accepts: got %0d want 1", wb_cnt); end
    if (wb_cnt >= 1) begin
      vec_cnt++; if (acc_way_q[0] !== 3'd7) begin err_cnt++; $display("[TB] FAIL stall_way: got %0d want 7", acc_way_q[0]); end
      vec_cnt++; if (acc_addr_q[0] !== {44'h123, 2'd1, 4'd0}) begin err_cnt++; $display("[TB] FAIL stall_addr: got %0h want %0h", acc_addr_q[0], {44'h123, 2'd1, 4'd0}); end
    end
    vec_cnt++; if (ack_at <= 0) begin err_cnt++; $display("[TB] FAIL stall_ack: got %0d want >0", ack_at); end
    ready_delay = 0;
  endtask

  task automatic test_clean_or_invalid();
    int ack_at, gap;
    clear_mem();
    valid_mem[0] = 8'hFF; dirty_mem[0] = 8'h00;
    valid_mem[3] = 8'h00; dirty_mem[3] = 8'hFF;
    do_flush(0, 0, ack_at, gap);
    vec_cnt++; if (wb_cnt !== 0) begin err_cnt++; $display("[TB] FAIL ci_wb: got %0d want 0", wb_cnt); end
    vec_cnt++; if (inv_cnt !== 4) begin err_cnt++; $display("[TB] FAIL ci_invalidates: got %0d want 4", inv_cnt); end
    vec_cnt++; if (ack_at !== 13) begin err_cnt++; $display("[TB] FAIL ci_ack_cycle: got %0d want 13", ack_at); end
    vec_cnt++; if (valid_mem[0] !== 8'h00) begin err_cnt++; $display("[TB] FAIL ci_set0_cleared: got %0h want 0", valid_mem[0]); end
  endtask

  task automatic test_back_to_back();
    int ack_at, gap;
    clear_mem();
    do_flush(1, 0, ack_at, gap);
    repeat (5) @(negedge clk_i);
    vec_cnt++; if (rd_cnt !== 4) begin err_cnt++; $display("[TB] FAIL b2b_no_rewalk: got %0d reads want 4", rd_cnt); end
    vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL b2b_idle: got %b want 0", busy_o); end
    vec_cnt++; if (ack_cnt !== 1) begin err_cnt++; $display("[TB] FAIL b2b_ack_once: got %0d want 1", ack_cnt); end
    repeat (3) @(negedge clk_i);
    do_flush(0, 0, ack_at, gap);
    vec_cnt++; if (ack_at !== 13) begin err_cnt++; $display("[TB] FAIL b2b_second_ack: got %0d want 13", ack_at); end
    vec_cnt++; if (rd_cnt !== 4) begin err_cnt++; $display("[TB] FAIL b2b_second_reads: got %0d want 4", rd_cnt); end
  endtask

  task automatic test_flush_drop();
    int ack_at, gap;
    clear_mem();
    do_flush(0, 3, ack_at, gap);
    vec_cnt++; if (ack_at !== 13) begin err_cnt++; $display("[TB] FAIL drop_ack_cycle: got %0d want 13", ack_at); end
    vec_cnt++; if (inv_cnt !== 4) begin err_cnt++; $display("[TB] FAIL drop_invalidates: got %0d want 4", inv_cnt); end
  endtask

  task automatic test_mid_reset();
    int ack_at, gap;
    clear_mem();
    valid_mem[0] = 8'h08; dirty_mem[0] = 8'h08; tag_mem[0][3] = 44'h55;
    done_delay = 1000;
    clear_counters();
    flush_i = 1'b1;
    for (int i = 0; i < 100 && wb_cnt < 1; i++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1; flush_i = 1'b0; pend_done = 0;
    @(negedge clk_i);
    vec_cnt++; if (busy_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL mrst_busy: got %b want 0", busy_o); end
    vec_cnt++; if (meta_idx_o !== 2'd0) begin err_cnt++; $display("[TB] FAIL mrst_idx: got %0d want 0", meta_idx_o); end
    vec_cnt++; if (wb_valid_o !== 1'b0) begin err_cnt++; $display("[TB] FAIL mrst_wb_valid: got %b want 0", wb_valid_o); end
    rst_i = 1'b0;
    done_delay = 2;
    @(negedge clk_i);
    do_flush(0, 0, ack_at, gap);
    vec_cnt++; if (ack_at <= 0) begin err_cnt++; $display("[TB] FAIL mrst_reflush_ack: got %0d want >0", ack_at); end
    vec_cnt++; if (wb_cnt !== 1) begin err_cnt++; $display("[TB] FAIL mrst_reflush_wb: got %0d want 1", wb_cnt); end
    if (wb_cnt >= 1) begin
      vec_cnt++; if (acc_addr_q[0] !== {44'h55, 2'd0, 4'd0}) begin err_cnt++; $display("[TB] FAIL mrst_addr: got %0h want %0h", acc_addr_q[0], {44'h55, 2'd0, 4'd0}); end
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_all_clean();
    test_writeback();
    test_ready_stall();
    test_clean_or_invalid();
    test_back_to_back();
    test_flush_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
